// File: rtl/difftest_commit_if.sv
// Bundle between the writeback stage, the difftest commit checker and the
// commit source. The master side drives retires and sink readiness; the slave
// side (the commit source) returns commits and status.
interface difftest_commit_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_pc;
  logic [DATA_W-1:0] wb_debug_pc;
  logic              wb_ebreak;
  logic              wb_ready;
  logic              timer_int;
  logic              dt_ready;
  logic              inst_commit;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] debug_pc;
  logic              cpu_timer_int;
  logic              cpu_ebreak_sign;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output wb_valid, wb_pc, wb_debug_pc, wb_ebreak, timer_int, dt_ready,
    input  wb_ready, inst_commit, pc, debug_pc, cpu_timer_int,
           cpu_ebreak_sign, count, overflow
  );

  modport slave (
    input  wb_valid, wb_pc, wb_debug_pc, wb_ebreak, timer_int, dt_ready,
    output wb_ready, inst_commit, pc, debug_pc, cpu_timer_int,
           cpu_ebreak_sign, count, overflow
  );
endinterface

// File: rtl/difftest_commit_source.sv
// Producer side of the difftest commit channel. Retired-instruction records
// are queued in a small FIFO and drained as single-cycle commit pulses, with
// timer-interrupt and ebreak flags travelling alongside their record. The
// channel freezes after an ebreak record commits, until reset.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | accepting retires and draining commits
//   ST_HALT | ebreak committed; no push, no pop, queue frozen until reset
module difftest_commit_source #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  difftest_commit_if.slave  dt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] dpc;
    logic              ebreak;
    logic              tint;
  } entry_t;

  state_e            state_q, state_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              commit_q, commit_d;
  logic              tint_q, tint_d;
  logic              ebrk_q, ebrk_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] dpc_q, dpc_d;

  entry_t            mem_q [DEPTH];
  entry_t            head;
  entry_t            wr_ent;
  logic [PW-1:0]     count_w;
  logic              ready_w;
  logic              push;
  logic              pop;

  // Occupancy comes straight from the pointer difference; a pop in the same
  // cycle does not free a slot for the incoming retire.
  assign count_w = wptr_q - rptr_q;
  assign ready_w = (state_q == ST_RUN) && (count_w < PW'(DEPTH));
  assign push    = dt.wb_valid && ready_w;
  assign pop     = (state_q == ST_RUN) && (count_w != '0) && dt.dt_ready;
  assign head    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wr_ent        = '0;
    wr_ent.pc     = dt.wb_pc;
    wr_ent.dpc    = dt.wb_debug_pc;
    wr_ent.ebreak = dt.wb_ebreak;
    wr_ent.tint   = pend_q | dt.timer_int;
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wr_ent;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      wptr_q   <= '0;
      rptr_q   <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      commit_q <= 1'b0;
      tint_q   <= 1'b0;
      ebrk_q   <= 1'b0;
      pc_q     <= '0;
      dpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      commit_q <= commit_d;
      tint_q   <= tint_d;
      ebrk_q   <= ebrk_d;
      pc_q     <= pc_d;
      dpc_q    <= dpc_d;
    end
  end

  // Next-state: FSM transition, FIFO pointer moves and commit output load.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    ovf_d    = ovf_q;
    commit_d = 1'b0;
    tint_d   = 1'b0;
    ebrk_d   = 1'b0;
    pc_d     = pc_q;
    dpc_d    = dpc_q;
    // An interrupt seen with no accepted record waits for the next one.
    pend_d   = (pend_q | dt.timer_int) & ~push;

    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end

    if ((state_q == ST_RUN) && dt.wb_valid && !ready_w) begin
      ovf_d = 1'b1;
    end

    if (pop) begin
      rptr_d   = rptr_q + PW'(1);
      commit_d = 1'b1;
      pc_d     = head.pc;
      dpc_d    = head.dpc;
      tint_d   = head.tint;
      ebrk_d   = head.ebreak;
    end

    case (state_q)
      ST_RUN:  if (pop && head.ebreak) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  assign dt.wb_ready        = ready_w;
  assign dt.inst_commit     = commit_q;
  assign dt.pc              = pc_q;
  assign dt.debug_pc        = dpc_q;
  assign dt.cpu_timer_int   = tint_q;
  assign dt.cpu_ebreak_sign = ebrk_q;
  assign dt.count           = count_w;
  assign dt.overflow        = ovf_q;
endmodule

// File: tb/tb_difftest_commit_source.sv
// Bench for difftest_commit_source: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_difftest_commit_source;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  difftest_commit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  difftest_commit_source #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
    .clock (clock),
    .reset (reset),
    .dt    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] dpc;
    bit          eb;
    bit          ti;
  } ent_t;

  ent_t        m_q[$];
  bit          m_pend, m_halt, m_ovf;
  bit          e_commit, e_ti, e_eb;
  logic [63:0] e_pc, e_dpc;
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] next_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_pend   = 0;
    m_halt   = 0;
    m_ovf    = 0;
    e_commit = 0;
    e_ti     = 0;
    e_eb     = 0;
    e_pc     = '0;
    e_dpc    = '0;
  endtask

  task automatic check_all();
    chk("inst_commit", 64'(bus.inst_commit), 64'(e_commit));
    chk("pc", bus.pc, e_pc);
    chk("debug_pc", bus.debug_pc, e_dpc);
    chk("cpu_timer_int", 64'(bus.cpu_timer_int), 64'(e_ti));
    chk("cpu_ebreak_sign", 64'(bus.cpu_ebreak_sign), 64'(e_eb));
    chk("count", 64'(bus.count), 64'(m_q.size()));
    chk("count_le_depth", 64'(bus.count <= DEPTH), 64'd1);
    chk("wb_ready", 64'(bus.wb_ready), 64'(!m_halt && m_q.size() < DEPTH));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
  endtask

  // One clock: inputs driven at the falling edge, model advanced for the
  // coming rising edge, outputs compared at the following falling edge.
  task automatic step(input bit v, input logic [63:0] pc, input logic [63:0] dpc,
                      input bit eb, input bit ti, input bit dr);
    bit   rdy, do_pop, do_push;
    ent_t h, n;
    bus.wb_valid    = v;
    bus.wb_pc       = pc;
    bus.wb_debug_pc = dpc;
    bus.wb_ebreak   = eb;
    bus.timer_int   = ti;
    bus.dt_ready    = dr;

    rdy     = !m_halt && (m_q.size() < DEPTH);
    do_push = v && rdy;
    do_pop  = !m_halt && (m_q.size() > 0) && dr;
    if (!m_halt && v && !rdy) m_ovf = 1;
    e_commit = 0;
    e_ti     = 0;
    e_eb     = 0;
    if (do_pop) begin
      h        = m_q.pop_front();
      e_commit = 1;
      e_pc     = h.pc;
      e_dpc    = h.dpc;
      e_ti     = h.ti;
      e_eb     = h.eb;
      if (h.eb) m_halt = 1;
    end
    if (do_push) begin
      n.pc  = pc;
      n.dpc = dpc;
      n.eb  = eb;
      n.ti  = m_pend | ti;
      m_q.push_back(n);
    end
    m_pend = (m_pend | ti) && !do_push;

    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, dr);
  endtask

  // Reset asserted mid-cycle: outputs must drop immediately, then release
  // at a falling edge so the next rising edge sees it deasserted.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_inst_commit", 64'(bus.inst_commit), 64'd0);
    chk("rst_pc", bus.pc, 64'd0);
    chk("rst_debug_pc", bus.debug_pc, 64'd0);
    chk("rst_cpu_timer_int", 64'(bus.cpu_timer_int), 64'd0);
    chk("rst_cpu_ebreak_sign", 64'(bus.cpu_ebreak_sign), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_wb_ready", 64'(bus.wb_ready), 64'd1);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    model_clear();
    bus.wb_valid  = 0;
    bus.timer_int = 0;
    bus.dt_ready  = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bus.wb_valid    = 0;
    bus.wb_pc       = '0;
    bus.wb_debug_pc = '0;
    bus.wb_ebreak   = 0;
    bus.timer_int   = 0;
    bus.dt_ready    = 0;
    model_clear();
    @(negedge clock);
    do_reset();

    // single retire, two-edge latency
    step(1, 64'h8000_0000, 64'h8000_0004, 0, 0, 1);
    idle(4, 1);

    // fill with sink stalled, overflow on fifth offer, then drain in order
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 64'h1000 + 64'(4 * i), 64'h2000 + 64'(4 * i), 0, 0, 0);
    idle(6, 1);

    // one-cycle interrupt tags only the next accepted record
    do_reset();
    step(0, '0, '0, 0, 1, 1);
    step(1, 64'h200, 64'h204, 0, 0, 1);
    step(1, 64'h204, 64'h208, 0, 0, 1);
    idle(4, 1);

    // ebreak halts the channel; later retires are refused without overflow
    do_reset();
    step(1, 64'h100, 64'h104, 0, 0, 1);
    step(1, 64'h104, 64'h108, 1, 0, 1);
    step(1, 64'h108, 64'h10c, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 64'h10c, 64'h110, 0, 1, 1);
    chk("halt_wb_ready", 64'(bus.wb_ready), 64'd0);

    // reset with queued entries, no stale commit afterwards
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 64'h300 + 64'(4 * i), 64'h304 + 64'(4 * i), 0, 0, 0);
    do_reset();
    idle(3, 1);
    step(1, 64'h400, 64'h404, 0, 0, 1);
    idle(3, 1);

    // random traffic
    for (int r = 0; r < 6; r++) begin
      do_reset();
      next_pc = 64'h8000_0000;
      for (int i = 0; i < 300; i++) begin
        bit v, dr, ti, eb;
        v  = ($urandom_range(0, 9) < 6);
        dr = ($urandom_range(0, 9) < (r < 3 ? 6 : 3));
        ti = ($urandom_range(0, 9) == 0);
        eb = (r >= 3) && ($urandom_range(0, 99) == 0);
        step(v, next_pc, next_pc + 64'd4, eb, ti, dr);
        if (v) next_pc = next_pc + 64'd4;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
